wdt_timeout_ctrl: RTL
=====================

# wdt_timeout_ctrl

Watchdog supervisor that drives a free-running up-counter through its `enable`/`clear`/`init_value` inputs and monitors the counter's registered `counter_value` output. Software services it with a two-key kick sequence over a valid/ready port. It raises a warning interrupt at a configurable threshold and a fixed-length reset request at timeout. It sits beside the watchdog counter inside the WDT subsystem, between the register file and the SoC reset controller.

## Interface
Parameters:
- `RST_PULSE_LEN`, default 16: number of cycles `rst_req_o` is held high; must be ≥ 1.
- `KICK_KEY1`, default 32'hA5A5_A5A5: first kick key.
- `KICK_KEY2`, default 32'h5A5A_5A5A: second kick key.

Ports:
- `clk_i` input 1: clock.
- `rst_ni` input 1: reset, asynchronous, active-low.
- `cfg_enable_i` input 1: watchdog enable (level).
- `cfg_init_i` input 32: counter reload value.
- `cfg_warn_thr_i` input 32: warning threshold (unsigned).
- `cfg_timeout_i` input 32: timeout threshold (unsigned).
- `kick_valid_i` input 1: kick word valid.
- `kick_data_i` input 32: kick word.
- `kick_ready_o` output 1: kick word accepted when valid and ready are both high.
- `cnt_value_i` input 32: current counter value (registered on the counter side).
- `cnt_enable_o` output 1: counter increment enable.
- `cnt_clear_o` output 1: counter load-init request.
- `cnt_init_o` output 32: counter init value; combinational copy of `cfg_init_i`.
- `warn_irq_o` output 1: warning interrupt (level).
- `rst_req_o` output 1: reset request pulse.
- `state_o` output 2: FSM state encoding: IDLE=0, RUN=1, WARN=2, BITE=3.

## Operation
- FSM states: IDLE, RUN, WARN, BITE. All outputs except `cnt_init_o` are registered or decoded from state registers.
- Clear masking: a "compare" means an unsigned 32-bit `cnt_value_i` ≥ threshold test. Compares are ignored in any cycle where `cnt_clear_o` = 1, because the counter value is stale until the load completes.
- IDLE:
  - `cnt_clear_o` = 1, `cnt_enable_o` = 0, `kick_ready_o` = 0.
  - `cfg_enable_i` = 1 → RUN.
- RUN:
  - `cnt_enable_o` = 1, `kick_ready_o` = 1.
  - Timeout compare true → BITE.
  - Otherwise, warn compare true → WARN.
  - `cfg_enable_i` = 0 → IDLE.
- WARN:
  - Same as RUN, plus `warn_irq_o` = 1.
  - Timeout compare true → BITE.
  - Successful kick → RUN.
  - `cfg_enable_i` = 0 → IDLE.
- BITE:
  - `rst_req_o` = 1, `cnt_clear_o` = 1, `cnt_enable_o` = 0, `kick_ready_o` = 0.
  - A pulse counter runs for `RST_PULSE_LEN` cycles, then → IDLE.
  - BITE cannot be aborted by `cfg_enable_i` = 0 or by kicks.
- Kick sequence (handshakes only occur in RUN/WARN). Internal flag `key_armed` is reset to 0.
  - Not armed, data = `KICK_KEY1` → set `key_armed`.
  - Not armed, any other data → ignored.
  - Armed, data = `KICK_KEY2` → successful kick: `cnt_clear_o` = 1 for exactly the next cycle, clear `key_armed`.
  - Armed, any other data (including `KICK_KEY1`) → BITE next cycle. A bad second key is treated as a fault.
  - `key_armed` clears on entry to IDLE or BITE.
- Threshold ordering:
  - If `cfg_warn_thr_i` ≥ `cfg_timeout_i`, WARN is never entered; timeout takes precedence.
  - Thresholds are sampled live each cycle, not latched.
- Priority when events coincide in one cycle:
  - BITE entry (timeout or bad key) beats a successful kick.
  - A successful kick beats WARN entry.
  - `cfg_enable_i` = 0 beats all of them except BITE entry.
- Counter wrap: not handled. Any `cfg_timeout_i` ≤ 32'hFFFF_FFFF is reached before wrap. With timeout = 32'hFFFF_FFFF, BITE triggers when the value reaches all-ones.

## Timing
- Reset values:
  - state IDLE; `state_o` = 0.
  - `cnt_clear_o` = 1.
  - `cnt_enable_o`, `kick_ready_o`, `warn_irq_o`, `rst_req_o` = 0.
  - `key_armed` = 0; pulse counter = 0.
- `cfg_enable_i` rises in cycle T → RUN in T+1: `cnt_clear_o` = 0 and `cnt_enable_o` = 1 in T+1.
- Compare true in cycle T → new state and its outputs visible in T+1. Examples: `warn_irq_o` rises in T+1; `rst_req_o` rises in T+1.
- `rst_req_o` stays high for exactly `RST_PULSE_LEN` cycles. IDLE follows in the next cycle; if `cfg_enable_i` = 1, RUN follows one cycle after that.
- Successful kick handshake in T:
  - `cnt_clear_o` = 1 in T+1; counter holds `cfg_init_i` from T+2.
  - Compares are masked in T+1.
  - From WARN: state = RUN and `warn_irq_o` = 0 in T+1.
- Reset asserted mid-operation (e.g. during BITE): all state is forced to the reset values immediately and asynchronously; no residual `rst_req_o`.

## Test plan
- Enable with init=0, warn=10, timeout=20, no kicks:
  - `warn_irq_o` rises one cycle after `cnt_value_i` = 10.
  - `rst_req_o` rises one cycle after `cnt_value_i` = 20 and is high exactly 16 cycles.
  - Then `state_o` returns to 0 and then 1.
- Kick A5A5_A5A5 then 5A5A_5A5A at count 15 while in WARN:
  - Next cycle `cnt_clear_o` = 1, `warn_irq_o` = 0, `state_o` = 1.
  - Counter restarts from 0; no `rst_req_o`.
- Kick A5A5_A5A5 then 1234_5678 → BITE next cycle, `rst_req_o` high 16 cycles. Kick 1234_5678 alone in RUN → ignored, no state change.
- Successful kick handshake in the same cycle `cnt_value_i` = timeout = 20 → BITE wins; `cnt_clear_o` is driven only by BITE.
- warn=30, timeout=20 → `warn_irq_o` never asserts; BITE one cycle after value 20.
- Deassert `cfg_enable_i` in WARN → IDLE next cycle, `warn_irq_o` = 0, `cnt_clear_o` = 1. Deassert during BITE → pulse still completes its 16 cycles. Assert `rst_ni` low mid-BITE → all outputs at reset values immediately.

Source files
------------

// File: rtl/wdt_timeout_ctrl.sv
// Watchdog supervisor: sequences an external up-counter, raises a warning at a
// threshold and a fixed-length reset request at timeout; serviced by a two-key kick.
module wdt_timeout_ctrl #(
  parameter int unsigned RST_PULSE_LEN = 16,
  parameter logic [31:0] KICK_KEY1     = 32'hA5A5_A5A5,
  parameter logic [31:0] KICK_KEY2     = 32'h5A5A_5A5A
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cfg_enable_i,
  input  logic [31:0] cfg_init_i,
  input  logic [31:0] cfg_warn_thr_i,
  input  logic [31:0] cfg_timeout_i,
  input  logic        kick_valid_i,
  input  logic [31:0] kick_data_i,
  output logic        kick_ready_o,
  input  logic [31:0] cnt_value_i,
  output logic        cnt_enable_o,
  output logic        cnt_clear_o,
  output logic [31:0] cnt_init_o,
  output logic        warn_irq_o,
  output logic        rst_req_o,
  output logic [1:0]  state_o
);

  localparam int unsigned PULSE_W = (RST_PULSE_LEN > 1) ? $clog2(RST_PULSE_LEN) : 1;
  localparam logic [PULSE_W-1:0] PULSE_LAST = PULSE_W'(RST_PULSE_LEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    WARN = 2'd2,
    BITE = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic               key_armed_q, key_armed_d;
  logic               kick_clr_q, kick_clr_d;
  logic [PULSE_W-1:0] pulse_cnt_q, pulse_cnt_d;

  logic active;
  logic cmp_en;
  logic timeout_hit;
  logic warn_hit;
  logic kick_fire;
  logic key_arm;
  logic good_kick;
  logic bad_kick;

  // Outputs decoded directly from the state registers
  assign active       = (state_q == RUN) || (state_q == WARN);
  assign kick_ready_o = active;
  assign cnt_enable_o = active;
  assign cnt_clear_o  = (state_q == IDLE) || (state_q == BITE) || kick_clr_q;
  assign warn_irq_o   = (state_q == WARN);
  assign rst_req_o    = (state_q == BITE);
  assign state_o      = state_q;
  assign cnt_init_o   = cfg_init_i;

  // The counter value is stale while a load is pending, so compares are masked
  assign cmp_en      = ~cnt_clear_o;
  assign timeout_hit = cmp_en && (cnt_value_i >= cfg_timeout_i);
  assign warn_hit    = cmp_en && (cnt_value_i >= cfg_warn_thr_i);

  assign kick_fire = kick_valid_i && kick_ready_o;
  assign key_arm   = kick_fire && !key_armed_q && (kick_data_i == KICK_KEY1);
  assign good_kick = kick_fire &&  key_armed_q && (kick_data_i == KICK_KEY2);
  assign bad_kick  = kick_fire &&  key_armed_q && (kick_data_i != KICK_KEY2);

  // Next-state: bite beats disable, disable beats kick, kick beats warn
  always_comb begin
    state_d     = state_q;
    key_armed_d = key_armed_q;
    kick_clr_d  = 1'b0;
    pulse_cnt_d = pulse_cnt_q;

    case (state_q)
      IDLE: begin
        key_armed_d = 1'b0;
        pulse_cnt_d = '0;
        if (cfg_enable_i) begin
          state_d = RUN;
        end
      end

      RUN, WARN: begin
        if (key_arm) begin
          key_armed_d = 1'b1;
        end
        if (good_kick || bad_kick) begin
          key_armed_d = 1'b0;
        end

        if (timeout_hit || bad_kick) begin
          state_d     = BITE;
          key_armed_d = 1'b0;
          pulse_cnt_d = '0;
        end else if (!cfg_enable_i) begin
          state_d     = IDLE;
          key_armed_d = 1'b0;
        end else if (good_kick) begin
          state_d    = RUN;
          kick_clr_d = 1'b1;
        end else if (warn_hit) begin
          state_d = WARN;
        end
      end

      BITE: begin
        key_armed_d = 1'b0;
        if (pulse_cnt_q == PULSE_LAST) begin
          state_d     = IDLE;
          pulse_cnt_d = '0;
        end else begin
          pulse_cnt_d = pulse_cnt_q + PULSE_W'(1);
        end
      end

      default: begin
        state_d     = IDLE;
        key_armed_d = 1'b0;
        pulse_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      key_armed_q <= 1'b0;
      kick_clr_q  <= 1'b0;
      pulse_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      key_armed_q <= key_armed_d;
      kick_clr_q  <= kick_clr_d;
      pulse_cnt_q <= pulse_cnt_d;
    end
  end

endmodule
